// File: rtl/hist_bin_engine_pkg.sv
// Shared definitions for the histogram engine and the UART controller that
// reads it out: default geometry of the bin memory and the control FSM encoding.
package hist_bin_engine_pkg;

    localparam int HIST_BIN_DATAWIDTH_DEF = 16;
    localparam int NUM_BINS_DEF           = 512;
    localparam int BIN_ADDR_W_DEF         = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } hist_state_t;

endpackage

// File: rtl/hist_dpram.sv
// Bin memory: one write port plus a registered read on port A for the
// increment pipeline and clear sweep, and an independent registered read
// on port B for readout. No reset so that it maps onto block RAM.
module hist_dpram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [ADDR_W-1:0] a_raddr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Port A: write when requested and read the addressed word (old data on collision)
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_waddr] <= a_wdata;
        end
        a_rdata <= mem[a_raddr];
    end

    // Port B: registered readout, returns old data when port A writes the same word
    always_ff @(posedge clk) begin
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/hist_bin_engine.sv
// Histogram binning engine: a control FSM (IDLE/RUN/CLEAR), a memory clear
// sweep, a three-stage saturating read-modify-write increment pipeline with
// forwarding, and a latency-1 readout port.
module hist_bin_engine
    import hist_bin_engine_pkg::*;
#(
    parameter int HIST_BIN_DATAWIDTH = HIST_BIN_DATAWIDTH_DEF,
    parameter int NUM_BINS           = NUM_BINS_DEF,
    parameter int BIN_ADDR_W         = BIN_ADDR_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sample_valid,
    input  logic [BIN_ADDR_W-1:0]         sample_bin,
    input  logic                          start_sig_to_hist,
    input  logic                          stop_sig_to_hist,
    input  logic                          clear_sig_to_hist,
    input  logic [BIN_ADDR_W-1:0]         address_to_hist,
    output logic [HIST_BIN_DATAWIDTH-1:0] histogram_bin_data,
    output logic                          bram_reset_done,
    output logic                          hist_running,
    output logic                          bin_saturated
);

    localparam logic [HIST_BIN_DATAWIDTH-1:0] COUNT_MAX = '1;
    localparam logic [BIN_ADDR_W-1:0] LAST_ADDR = BIN_ADDR_W'(NUM_BINS - 1);

    hist_state_t state, state_next;

    logic [BIN_ADDR_W-1:0]         sweep_cnt;
    logic                          sweep_last;
    logic                          cmd_clear;

    logic                          accept;
    logic                          s1_valid, s2_valid, s3_valid, wb_valid;
    logic [BIN_ADDR_W-1:0]         s1_bin, s2_bin, s3_bin, wb_bin;
    logic [HIST_BIN_DATAWIDTH-1:0] s2_old, s2_new, s3_data, wb_data;
    logic [HIST_BIN_DATAWIDTH-1:0] s1_fwd;

    logic                          a_we;
    logic [BIN_ADDR_W-1:0]         a_waddr;
    logic [HIST_BIN_DATAWIDTH-1:0] a_wdata;
    logic [HIST_BIN_DATAWIDTH-1:0] a_rdata;
    logic [HIST_BIN_DATAWIDTH-1:0] b_rdata;
    logic                          rd_valid;

    assign sweep_last   = (state == CLEAR) && (sweep_cnt == LAST_ADDR);
    assign accept       = sample_valid && (state == RUN) && !clear_sig_to_hist;
    assign hist_running = (state == RUN);

    // Control state register; reset lands in CLEAR so memory is swept before use
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic with clear taking priority over stop, and stop over start
    always_comb begin
        state_next = state;
        if (clear_sig_to_hist) begin
            state_next = CLEAR;
        end else begin
            case (state)
                IDLE:    if (start_sig_to_hist) state_next = RUN;
                RUN:     if (stop_sig_to_hist)  state_next = IDLE;
                CLEAR:   if (sweep_last)        state_next = cmd_clear ? RUN : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Sweep address, origin of the sweep (command or reset) and the done level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sweep_cnt       <= '0;
            cmd_clear       <= 1'b0;
            bram_reset_done <= 1'b0;
        end else if (clear_sig_to_hist) begin
            sweep_cnt       <= '0;
            cmd_clear       <= 1'b1;
            bram_reset_done <= 1'b0;
        end else if (state == CLEAR) begin
            if (sweep_last) begin
                bram_reset_done <= 1'b1;
            end else begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    // Pick the freshest value of the S1 bin: S2 result, S3 pending write, last write, then RAM
    always_comb begin
        s1_fwd = a_rdata;
        if (s2_valid && (s2_bin == s1_bin)) begin
            s1_fwd = s2_new;
        end else if (s3_valid && (s3_bin == s1_bin)) begin
            s1_fwd = s3_data;
        end else if (wb_valid && (wb_bin == s1_bin)) begin
            s1_fwd = wb_data;
        end
    end

    assign s2_new = (s2_old == COUNT_MAX) ? COUNT_MAX : s2_old + HIST_BIN_DATAWIDTH'(1);

    // Port A write source: zeros during the sweep, otherwise the S3 write-back; nothing on clear
    always_comb begin
        a_we    = 1'b0;
        a_waddr = s3_bin;
        a_wdata = s3_data;
        if (!clear_sig_to_hist) begin
            if (state == CLEAR) begin
                a_we    = 1'b1;
                a_waddr = sweep_cnt;
                a_wdata = '0;
            end else if (s3_valid) begin
                a_we = 1'b1;
            end
        end
    end

    // Increment pipeline registers; clear flushes every stage, stop lets them drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            wb_valid <= 1'b0;
            s1_bin   <= '0;
            s2_bin   <= '0;
            s3_bin   <= '0;
            wb_bin   <= '0;
            s2_old   <= '0;
            s3_data  <= '0;
            wb_data  <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid && !clear_sig_to_hist;
            s3_valid <= s2_valid && !clear_sig_to_hist;
            wb_valid <= a_we;
            s1_bin   <= sample_bin;
            s2_bin   <= s1_bin;
            s3_bin   <= s2_bin;
            wb_bin   <= a_waddr;
            s2_old   <= s1_fwd;
            s3_data  <= s2_new;
            wb_data  <= a_wdata;
        end
    end

    // Sticky saturation flag, set when an increment finds the bin already at maximum
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_saturated <= 1'b0;
        end else if (clear_sig_to_hist) begin
            bin_saturated <= 1'b0;
        end else if (s2_valid && (s2_old == COUNT_MAX)) begin
            bin_saturated <= 1'b1;
        end
    end

    // Readout qualifier so the output reads zero from reset until the RAM has been clocked
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b1;
        end
    end

    assign histogram_bin_data = rd_valid ? b_rdata : '0;

    hist_dpram #(
        .DATA_W (HIST_BIN_DATAWIDTH),
        .DEPTH  (NUM_BINS),
        .ADDR_W (BIN_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .a_we    (a_we),
        .a_waddr (a_waddr),
        .a_wdata (a_wdata),
        .a_raddr (sample_bin),
        .a_rdata (a_rdata),
        .b_addr  (address_to_hist),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_hist_bin_engine.sv
// Directed testbench for hist_bin_engine: reset sweep, streaming increments,
// forwarding, saturation, clear/stop collision and reset during a sweep.
module tb_hist_bin_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [8:0]  sample_bin;
    logic        start_sig_to_hist;
    logic        stop_sig_to_hist;
    logic        clear_sig_to_hist;
    logic [8:0]  address_to_hist;
    logic [15:0] histogram_bin_data;
    logic        bram_reset_done;
    logic        hist_running;
    logic        bin_saturated;

    int total = 0;
    int bad   = 0;

    logic [15:0] rd;
    int          cyc;

    hist_bin_engine dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .sample_valid       (sample_valid),
        .sample_bin         (sample_bin),
        .start_sig_to_hist  (start_sig_to_hist),
        .stop_sig_to_hist   (stop_sig_to_hist),
        .clear_sig_to_hist  (clear_sig_to_hist),
        .address_to_hist    (address_to_hist),
        .histogram_bin_data (histogram_bin_data),
        .bram_reset_done    (bram_reset_done),
        .hist_running       (hist_running),
        .bin_saturated      (bin_saturated)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Count one comparison and report it when observed and expected differ
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs; they are sampled on the next rising edge
    task automatic applyStimulus(input logic v, input logic [8:0] b,
                                 input logic st, input logic sp, input logic cl);
        sample_valid      = v;
        sample_bin        = b;
        start_sig_to_hist = st;
        stop_sig_to_hist  = sp;
        clear_sig_to_hist = cl;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Latency-1 readout
    task automatic readBin(input logic [8:0] a, output logic [15:0] d);
        address_to_hist = a;
        @(negedge clk);
        d = histogram_bin_data;
    endtask

    // Wait for bram_reset_done with a bounded cycle budget, returning cycles waited
    task automatic waitDone(output int cycles);
        sample_valid      = 1'b0;
        start_sig_to_hist = 1'b0;
        stop_sig_to_hist  = 1'b0;
        clear_sig_to_hist = 1'b0;
        cycles = 0;
        while (!bram_reset_done && cycles < 1000) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        sample_valid      = 1'b0;
        sample_bin        = '0;
        start_sig_to_hist = 1'b0;
        stop_sig_to_hist  = 1'b0;
        clear_sig_to_hist = 1'b0;
        address_to_hist   = '0;

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("rst_data", 32'(histogram_bin_data), 32'h0);
        checkOutput("rst_done", 32'(bram_reset_done), 32'h0);
        checkOutput("rst_running", 32'(hist_running), 32'h0);
        checkOutput("rst_sat", 32'(bin_saturated), 32'h0);

        reset_n = 1'b1;
        waitDone(cyc);
        checkOutput("init_sweep_cycles", 32'(cyc), 32'd512);
        checkOutput("init_done", 32'(bram_reset_done), 32'h1);
        checkOutput("init_running", 32'(hist_running), 32'h0);
        readBin(9'd0, rd);   checkOutput("init_bin0", 32'(rd), 32'h0);
        readBin(9'd7, rd);   checkOutput("init_bin7", 32'(rd), 32'h0);
        readBin(9'd511, rd); checkOutput("init_bin511", 32'(rd), 32'h0);

        $display("[TB] five consecutive samples to bin 7");
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("stop_in_idle", 32'(hist_running), 32'h0);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_running", 32'(hist_running), 32'h1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 9'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("stop_idle", 32'(hist_running), 32'h0);
        idleCycles(5);
        readBin(9'd7, rd); checkOutput("bin7_count", 32'(rd), 32'd5);
        readBin(9'd8, rd); checkOutput("bin8_count", 32'(rd), 32'd0);

        $display("[TB] interleaved 3,4,3,4,3");
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("start_in_run", 32'(hist_running), 32'h1);
        applyStimulus(1'b1, 9'd4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        idleCycles(5);
        readBin(9'd3, rd); checkOutput("bin3_count", 32'(rd), 32'd3);
        readBin(9'd4, rd); checkOutput("bin4_count", 32'(rd), 32'd2);

        $display("[TB] forwarding distances 2, 1 and 3 on bin 9");
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd9, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd9, 1'b0, 1'b0, 1'b0);
        idleCycles(5);
        readBin(9'd9, rd); checkOutput("bin9_count", 32'(rd), 32'd4);

        $display("[TB] saturation on bin 0");
        for (int i = 0; i < 65534; i++) applyStimulus(1'b1, 9'd0, 1'b0, 1'b0, 1'b0);
        idleCycles(5);
        readBin(9'd0, rd); checkOutput("bin0_preload", 32'(rd), 32'hFFFE);
        checkOutput("sat_before", 32'(bin_saturated), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 9'd0, 1'b0, 1'b0, 1'b0);
        idleCycles(5);
        readBin(9'd0, rd); checkOutput("bin0_saturated", 32'(rd), 32'hFFFF);
        checkOutput("sat_after", 32'(bin_saturated), 32'h1);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] clear coincident with stop while streaming");
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 9'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd5, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_done_low", 32'(bram_reset_done), 32'h0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 9'd5, 1'b0, 1'b0, 1'b0);
        waitDone(cyc);
        checkOutput("clr_sweep_cycles", 32'(cyc + 8), 32'd512);
        checkOutput("clr_running", 32'(hist_running), 32'h1);
        checkOutput("clr_sat", 32'(bin_saturated), 32'h0);
        readBin(9'd0, rd);   checkOutput("clr_bin0", 32'(rd), 32'h0);
        readBin(9'd5, rd);   checkOutput("clr_bin5", 32'(rd), 32'h0);
        readBin(9'd7, rd);   checkOutput("clr_bin7", 32'(rd), 32'h0);
        readBin(9'd511, rd); checkOutput("clr_bin511", 32'(rd), 32'h0);

        $display("[TB] reset during sweep");
        applyStimulus(1'b1, 9'd300, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'd300, 1'b0, 1'b0, 1'b0);
        idleCycles(5);
        readBin(9'd300, rd); checkOutput("bin300_count", 32'(rd), 32'd2);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        idleCycles(200);
        checkOutput("midsweep_bin300", 32'(histogram_bin_data), 32'd2);
        checkOutput("midsweep_done", 32'(bram_reset_done), 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("arst_data", 32'(histogram_bin_data), 32'h0);
        checkOutput("arst_running", 32'(hist_running), 32'h0);
        checkOutput("arst_done", 32'(bram_reset_done), 32'h0);
        checkOutput("arst_sat", 32'(bin_saturated), 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        waitDone(cyc);
        checkOutput("rearm_sweep_cycles", 32'(cyc), 32'd512);
        checkOutput("rearm_running", 32'(hist_running), 32'h0);
        readBin(9'd300, rd); checkOutput("rearm_bin300", 32'(rd), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
